// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded operands and control, with
// hazard-unit stall (hold), flush (bubble insert) and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 16,
  parameter int REG_A_W = 3,
  parameter int BCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc1,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_A_W-1:0] id_rs,
  input  logic [REG_A_W-1:0] id_rt,
  input  logic [REG_A_W-1:0] id_rd,
  input  logic [1:0]         id_aluOp,
  input  logic [3:0]         id_func,
  input  logic [6:0]         id_ctrl,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc1,
  output logic [DATA_W-1:0]  ex_rd1,
  output logic [DATA_W-1:0]  ex_rd2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_A_W-1:0] ex_rs,
  output logic [REG_A_W-1:0] ex_rt,
  output logic [REG_A_W-1:0] ex_rd,
  output logic [1:0]         ex_aluOp,
  output logic [3:0]         ex_func,
  output logic [6:0]         ex_ctrl,
  output logic [BCNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc1;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [REG_A_W-1:0] rs;
    logic [REG_A_W-1:0] rt;
    logic [REG_A_W-1:0] rd;
    logic [1:0]         alu_op;
    logic [3:0]         func;
    logic [6:0]         ctrl;
  } slot_t;

  slot_t slot, slot_nxt;
  logic [BCNT_W-1:0] cnt;

  // An invalid ID slot may still carry stale control bits; mask them so it can never write.
  always_comb begin
    slot_nxt        = '0;
    slot_nxt.valid  = id_valid;
    slot_nxt.pc1    = id_pc1;
    slot_nxt.rd1    = id_rd1;
    slot_nxt.rd2    = id_rd2;
    slot_nxt.imm    = id_imm;
    slot_nxt.rs     = id_rs;
    slot_nxt.rt     = id_rt;
    slot_nxt.rd     = id_rd;
    slot_nxt.alu_op = id_aluOp;
    slot_nxt.func   = id_func;
    slot_nxt.ctrl   = id_valid ? id_ctrl : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      cnt  <= '0;
    end else if (flush) begin
      // All-zero slot is a no-write bubble; flush outranks stall.
      slot <= '0;
      if (cnt != {BCNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end else if (!stall) begin
      slot <= slot_nxt;
    end
  end

  assign ex_valid   = slot.valid;
  assign ex_pc1     = slot.pc1;
  assign ex_rd1     = slot.rd1;
  assign ex_rd2     = slot.rd2;
  assign ex_imm     = slot.imm;
  assign ex_rs      = slot.rs;
  assign ex_rt      = slot.rt;
  assign ex_rd      = slot.rd;
  assign ex_aluOp   = slot.alu_op;
  assign ex_func    = slot.func;
  assign ex_ctrl    = slot.ctrl;
  assign bubble_cnt = cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus pushes expected EX state, monitor pops and compares.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, id_valid;
  logic [15:0] id_pc1, id_rd1, id_rd2, id_imm;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluOp;
  logic [3:0]  id_func;
  logic [6:0]  id_ctrl;

  logic        ex_valid;
  logic [15:0] ex_pc1, ex_rd1, ex_rd2, ex_imm;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  ex_aluOp;
  logic [3:0]  ex_func;
  logic [6:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_valid;
  logic [15:0] s_pc1, s_rd1, s_rd2, s_imm;
  logic [2:0]  s_rs, s_rt, s_rd;
  logic [1:0]  s_aluOp;
  logic [3:0]  s_func;
  logic [6:0]  s_ctrl;
  logic [2:0]  s_cnt;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc1(id_pc1), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluOp(id_aluOp),
    .id_func(id_func), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc1(ex_pc1), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_aluOp(ex_aluOp), .ex_func(ex_func), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance to reach saturation quickly.
  id_ex_pipe_reg #(.BCNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc1(id_pc1), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluOp(id_aluOp),
    .id_func(id_func), .id_ctrl(id_ctrl),
    .ex_valid(s_valid), .ex_pc1(s_pc1), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_aluOp(s_aluOp), .ex_func(s_func), .ex_ctrl(s_ctrl),
    .bubble_cnt(s_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] pc1, rd1, rd2, imm;
    logic [2:0]  rs, rt, rd;
    logic [1:0]  alu_op;
    logic [3:0]  func;
    logic [6:0]  ctrl;
  } ex_t;

  typedef struct {
    ex_t ex;
    int  cnt;
    int  cnt3;
    string tag;
  } exp_t;

  exp_t q[$];
  ex_t  m_ex;
  int   m_cnt  = 0;
  int   m_cnt3 = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference: what EX should hold after the coming edge, derived from the priority rules.
  task automatic step(input logic r, input logic s, input logic f, input string tag);
    exp_t e;
    rst = r; stall = s; flush = f;
    if (r) begin
      m_ex = '0; m_cnt = 0; m_cnt3 = 0;
    end else if (f) begin
      m_ex = '0;
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : 7;
    end else if (!s) begin
      m_ex = '{valid: id_valid, pc1: id_pc1, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
               rs: id_rs, rt: id_rt, rd: id_rd, alu_op: id_aluOp, func: id_func,
               ctrl: (id_valid ? id_ctrl : 7'h00)};
    end
    e.ex = m_ex; e.cnt = m_cnt; e.cnt3 = m_cnt3; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_id();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc1 = 16'($urandom); id_rd1 = 16'($urandom);
    id_rd2 = 16'($urandom); id_imm = 16'($urandom);
    id_rs = 3'($urandom); id_rt = 3'($urandom); id_rd = 3'($urandom);
    id_aluOp = 2'($urandom); id_func = 4'($urandom); id_ctrl = 7'($urandom);
  endtask

  always @(posedge clk) begin
    exp_t e;
    ex_t  a, a3;
    #1;
    if (q.size() > 0) begin
      e  = q.pop_front();
      a  = '{ex_valid, ex_pc1, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_aluOp, ex_func, ex_ctrl};
      a3 = '{s_valid, s_pc1, s_rd1, s_rd2, s_imm, s_rs, s_rt, s_rd, s_aluOp, s_func, s_ctrl};
      n_chk++;
      if (a !== e.ex) begin
        n_fail++;
        $display("FAIL %s ex_state: got %h expected %h", e.tag, a, e.ex);
      end
      n_chk++;
      if (a3 !== e.ex) begin
        n_fail++;
        $display("FAIL %s ex_state_w3: got %h expected %h", e.tag, a3, e.ex);
      end
      n_chk++;
      if (bubble_cnt !== 16'(e.cnt)) begin
        n_fail++;
        $display("FAIL %s bubble_cnt: got %0d expected %0d", e.tag, bubble_cnt, e.cnt);
      end
      n_chk++;
      if (s_cnt !== 3'(e.cnt3)) begin
        n_fail++;
        $display("FAIL %s bubble_cnt_w3: got %0d expected %0d", e.tag, s_cnt, e.cnt3);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_pc1 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_aluOp = '0; id_func = '0; id_ctrl = '0;
    m_ex = '0;

    step(1, 0, 0, "reset0");
    step(1, 0, 0, "reset1");
    step(0, 0, 0, "post_reset");

    id_valid = 1; id_aluOp = 2'b10; id_func = 4'h3; id_ctrl = 7'b1000001; id_rd1 = 16'h00A5;
    id_pc1 = 16'h0011; id_rd2 = 16'h1234; id_imm = 16'hFFF0; id_rs = 3'd1; id_rt = 3'd2; id_rd = 3'd3;
    step(0, 0, 0, "load");

    id_aluOp = 2'b00; id_func = 4'h7; id_rd1 = 16'h5A5A;
    for (int i = 0; i < 3; i++) step(0, 1, 0, "stall_hold");
    step(0, 0, 0, "stall_release");

    step(0, 1, 1, "stall_flush");

    id_valid = 0; id_ctrl = 7'h7F;
    step(0, 0, 0, "invalid_slot");

    step(1, 0, 0, "sat_reset");
    for (int i = 0; i < 9; i++) step(0, 0, 1, "flush_sat");
    step(1, 0, 0, "sat_clear");

    for (int i = 0; i < 600; i++) begin
      rand_id();
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), "random");
    end

    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
